// File: rtl/sys_array_matrix_loader_pkg.sv
// ============================================================================
// Module  : sys_array_matrix_loader_pkg
// Brief   : Shared loader state encoding and counter sizing helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sys_array_matrix_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A    = 2'd0,
        LOAD_B    = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

    // Counters carry one spare bit above the largest dimension index.
    function automatic int cnt_width(input int rows, input int cols);
        return $clog2((rows > cols) ? rows : cols) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sys_array_matrix_loader_row_col_counter.sv
// ============================================================================
// Module  : matrix_row_col_counter
// Brief   : Row-major element position counter with wrap flag on last element.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_row_col_counter
    import sys_array_matrix_loader_pkg::*;
#(
    parameter int ROWS = 5,
    parameter int COLS = 2,
    parameter int CW   = cnt_width(ROWS, COLS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          wrap
);

    localparam logic [CW-1:0] C_LAST_ROW = CW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST_COL = CW'(COLS - 1);

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;

    // Clear wins over increment so an errored element restarts the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (r_col == C_LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == C_LAST_ROW) ? '0 : r_row + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign wrap = (r_row == C_LAST_ROW) && (r_col == C_LAST_COL);

endmodule

`default_nettype wire

// File: rtl/sys_array_matrix_loader.sv
// ============================================================================
// Module  : sys_array_matrix_loader
// Brief   : Fills operand arrays A then B from a valid/ready stream and runs
//           the start/complete handshake with the systolic fetcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sys_array_matrix_loader
    import sys_array_matrix_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_A_W  = 5,
    parameter int ARRAY_A_L  = 2,
    parameter int ARRAY_W_W  = 2,
    parameter int ARRAY_W_L  = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    input  logic                         comp_ready,
    output logic signed [DATA_WIDTH-1:0] input_data [0:ARRAY_A_W-1][0:ARRAY_A_L-1],
    output logic signed [DATA_WIDTH-1:0] weights    [0:ARRAY_W_W-1][0:ARRAY_W_L-1],
    output logic                         start_comp,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         done
);

    localparam int A_CW = cnt_width(ARRAY_A_W, ARRAY_A_L);
    localparam int B_CW = cnt_width(ARRAY_W_W, ARRAY_W_L);

    loader_state_t r_state;
    loader_state_t w_next_state;

    logic r_in_ready;
    logic r_start_comp;
    logic r_busy;
    logic r_frame_err;
    logic r_done;
    logic r_comp_prev;

    logic w_ready_nxt;
    logic w_start_nxt;
    logic w_busy_nxt;
    logic w_err_nxt;
    logic w_done_nxt;
    logic w_frame_err;

    logic w_accept;
    logic w_a_inc;
    logic w_b_inc;
    logic w_a_wrap;
    logic w_b_wrap;
    logic [A_CW-1:0] w_a_row;
    logic [A_CW-1:0] w_a_col;
    logic [B_CW-1:0] w_b_row;
    logic [B_CW-1:0] w_b_col;

    logic w_a_sel [ARRAY_A_W][ARRAY_A_L];
    logic w_b_sel [ARRAY_W_W][ARRAY_W_L];

    assign w_accept = in_valid && r_in_ready;
    assign w_a_inc  = w_accept && (r_state == LOAD_A);
    assign w_b_inc  = w_accept && (r_state == LOAD_B);

    matrix_row_col_counter #(
        .ROWS (ARRAY_A_W),
        .COLS (ARRAY_A_L),
        .CW   (A_CW)
    ) u_cnt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_a_inc),
        .clr     (w_frame_err),
        .row     (w_a_row),
        .col     (w_a_col),
        .wrap    (w_a_wrap)
    );

    matrix_row_col_counter #(
        .ROWS (ARRAY_W_W),
        .COLS (ARRAY_W_L),
        .CW   (B_CW)
    ) u_cnt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_b_inc),
        .clr     (w_frame_err),
        .row     (w_b_row),
        .col     (w_b_col),
        .wrap    (w_b_wrap)
    );

    generate
        for (genvar gi = 0; gi < ARRAY_A_W; gi++) begin : g_a_row
            for (genvar gj = 0; gj < ARRAY_A_L; gj++) begin : g_a_col
                assign w_a_sel[gi][gj] = (w_a_row == A_CW'(gi)) && (w_a_col == A_CW'(gj));
            end
        end
        for (genvar gi = 0; gi < ARRAY_W_W; gi++) begin : g_b_row
            for (genvar gj = 0; gj < ARRAY_W_L; gj++) begin : g_b_col
                assign w_b_sel[gi][gj] = (w_b_row == B_CW'(gi)) && (w_b_col == B_CW'(gj));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= LOAD_A;
            r_in_ready   <= 1'b0;
            r_start_comp <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_done       <= 1'b0;
            r_comp_prev  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_in_ready   <= w_ready_nxt;
            r_start_comp <= w_start_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_err  <= w_err_nxt;
            r_done       <= w_done_nxt;
            r_comp_prev  <= comp_ready;
        end
    end

    // Outputs are registered: the decode below selects next-cycle values.
    always_comb begin
        w_next_state = r_state;
        w_ready_nxt  = 1'b0;
        w_start_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            LOAD_A: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    if (in_last) begin
                        w_frame_err = 1'b1;
                    end else if (w_a_wrap) begin
                        w_next_state = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    if (in_last && w_b_wrap) begin
                        w_next_state = START;
                        w_ready_nxt  = 1'b0;
                        w_start_nxt  = 1'b1;
                        w_busy_nxt   = 1'b1;
                    end else if (in_last || w_b_wrap) begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            START: begin
                w_next_state = WAIT_DONE;
                w_busy_nxt   = 1'b1;
            end
            WAIT_DONE: begin
                w_busy_nxt = 1'b1;
                // Only a fresh rising edge counts; a level left high is ignored.
                if (comp_ready && !r_comp_prev) begin
                    w_next_state = LOAD_A;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_next_state = LOAD_A;
            end
        endcase
        if (w_frame_err) begin
            w_next_state = LOAD_A;
            w_err_nxt    = 1'b1;
        end
    end

    // Arrays are only written while loading, so they stay frozen for the fetcher.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARRAY_A_W; i++) begin
                for (int j = 0; j < ARRAY_A_L; j++) begin
                    input_data[i][j] <= '0;
                end
            end
        end else if (w_a_inc) begin
            for (int i = 0; i < ARRAY_A_W; i++) begin
                for (int j = 0; j < ARRAY_A_L; j++) begin
                    if (w_a_sel[i][j]) begin
                        input_data[i][j] <= in_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARRAY_W_W; i++) begin
                for (int j = 0; j < ARRAY_W_L; j++) begin
                    weights[i][j] <= '0;
                end
            end
        end else if (w_b_inc) begin
            for (int i = 0; i < ARRAY_W_W; i++) begin
                for (int j = 0; j < ARRAY_W_L; j++) begin
                    if (w_b_sel[i][j]) begin
                        weights[i][j] <= in_data;
                    end
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign start_comp = r_start_comp;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sys_array_matrix_loader.sv
// ============================================================================
// Module  : tb_sys_array_matrix_loader
// Brief   : Table-driven and randomized frames against a positional reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sys_array_matrix_loader;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int AL = 2;
    localparam int WW = 2;
    localparam int WL = 5;
    localparam int NA = AW * AL;
    localparam int NF = NA + WW * WL;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_last = 1'b0;
    logic                 in_ready;
    logic                 comp_ready = 1'b1;
    logic signed [DW-1:0] input_data [0:AW-1][0:AL-1];
    logic signed [DW-1:0] weights    [0:WW-1][0:WL-1];
    logic                 start_comp;
    logic                 busy;
    logic                 frame_err;
    logic                 done;

    always #5 clk = ~clk;

    sys_array_matrix_loader #(
        .DATA_WIDTH (DW),
        .ARRAY_A_W  (AW),
        .ARRAY_A_L  (AL),
        .ARRAY_W_W  (WW),
        .ARRAY_W_L  (WL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .comp_ready (comp_ready),
        .input_data (input_data),
        .weights    (weights),
        .start_comp (start_comp),
        .busy       (busy),
        .frame_err  (frame_err),
        .done       (done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: frame position -> flat row-major placement in A then B.
    int cyc = 0, acc_cnt = 0, start_cnt = 0, err_cnt = 0, done_cnt = 0;
    int last_acc_cyc = -10, start_cyc = -10, err_cyc = -10;
    int m_start = 0, m_err = 0, pos = 0;
    logic signed [DW-1:0] ea [AW][AL];
    logic signed [DW-1:0] eb [WW][WL];

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            pos = 0;
            for (int i = 0; i < AW; i++) for (int j = 0; j < AL; j++) ea[i][j] = '0;
            for (int i = 0; i < WW; i++) for (int j = 0; j < WL; j++) eb[i][j] = '0;
        end else begin
            if (start_comp) begin start_cnt++; start_cyc = cyc; end
            if (frame_err)  begin err_cnt++;   err_cyc = cyc;   end
            if (done) done_cnt++;
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (pos < NA) ea[pos / AL][pos % AL] = in_data;
                else          eb[(pos - NA) / WL][(pos - NA) % WL] = in_data;
                if (pos == NF - 1 && in_last) begin m_start++; pos = 0; end
                else if (in_last || pos == NF - 1) begin m_err++; pos = 0; end
                else pos++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic send_elem(input logic [DW-1:0] d, input logic l);
        int budget;
        budget = 40;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        sample();
        while (!in_ready && budget > 0) begin
            tick();
            sample();
            budget--;
        end
        if (budget == 0) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input int gap_max, input bit seq);
        for (int k = 0; k < n; k++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                in_data = DW'($urandom);
                tick();
            end
            send_elem(seq ? DW'(k + 1) : DW'($urandom), k == last_at);
        end
    endtask

    task automatic check_arrays(input string tag);
        for (int i = 0; i < AW; i++)
            for (int j = 0; j < AL; j++)
                chk($sformatf("%s_a[%0d][%0d]", tag, i, j), int'(input_data[i][j]), int'(ea[i][j]));
        for (int i = 0; i < WW; i++)
            for (int j = 0; j < WL; j++)
                chk($sformatf("%s_b[%0d][%0d]", tag, i, j), int'(weights[i][j]), int'(eb[i][j]));
    endtask

    task automatic check_idle_outputs(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < AW; i++) for (int j = 0; j < AL; j++) if (input_data[i][j] != 0) nz++;
        for (int i = 0; i < WW; i++) for (int j = 0; j < WL; j++) if (weights[i][j] != 0) nz++;
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_start"}, int'(start_comp), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(frame_err), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_arrays_zero"}, nz, 0);
    endtask

    task automatic release_reset();
        tick();
        reset_n = 1'b1;
        sample();
        chk("ready_before_edge", int'(in_ready), 0);
        sample();
        chk("ready_after_edge", int'(in_ready), 1);
        tick();
    endtask

    // Called right after the final-element accept edge, while in START.
    task automatic start_and_handshake(input string tag);
        int acc0, d0, s0;
        sample();
        chk({tag, "_start_pulse"}, int'(start_comp), 1);
        chk({tag, "_start_latency"}, start_cyc - last_acc_cyc, 1);
        chk({tag, "_busy_start"}, int'(busy), 1);
        chk({tag, "_ready_start"}, int'(in_ready), 0);
        s0 = start_cnt;
        in_valid = 1'b1;
        in_data  = 8'sh5a;
        in_last  = 1'b1;
        acc0 = acc_cnt;
        d0 = done_cnt;
        repeat (4) begin
            sample();
            chk({tag, "_busy_wait"}, int'(busy), 1);
            chk({tag, "_ready_wait"}, int'(in_ready), 0);
        end
        chk({tag, "_start_one_cycle"}, start_cnt, s0);
        chk({tag, "_no_done_while_high"}, done_cnt, d0);
        tick();
        comp_ready = 1'b0;
        repeat (3) tick();
        comp_ready = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        sample();
        chk({tag, "_done_not_yet"}, int'(done), 0);
        sample();
        chk({tag, "_done_pulse"}, int'(done), 1);
        chk({tag, "_busy_clear"}, int'(busy), 0);
        chk({tag, "_ready_after_done"}, int'(in_ready), 1);
        chk({tag, "_no_accept_busy"}, acc_cnt, acc0);
        sample();
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_done_count"}, done_cnt, d0 + 1);
        tick();
    endtask

    task automatic expect_error(input string tag, input int ms0, input int e0);
        sample();
        chk({tag, "_err_pulse"}, int'(frame_err), 1);
        chk({tag, "_err_latency"}, err_cyc - last_acc_cyc, 1);
        chk({tag, "_ready_err"}, int'(in_ready), 1);
        sample();
        chk({tag, "_err_one_cycle"}, int'(frame_err), 0);
        chk({tag, "_err_count"}, err_cnt, e0 + 1);
        chk({tag, "_no_start"}, start_cnt, ms0);
        tick();
    endtask

    typedef struct {
        string name;
        int    n;
        int    last_at;
        int    gap_max;
        bit    seq;
        bit    exp_start;
        int    exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{"nominal",      20, 19, 0, 1'b1, 1'b1, 0};
        vecs[1] = '{"early_last",    7,  6, 0, 1'b0, 1'b0, 1};
        vecs[2] = '{"recover",      20, 19, 2, 1'b0, 1'b1, 0};
        vecs[3] = '{"missing_last", 20, -1, 0, 1'b0, 1'b0, 1};
        vecs[4] = '{"last_on_a_end",10,  9, 0, 1'b0, 1'b0, 1};
        vecs[5] = '{"last_on_b0",   11, 10, 1, 1'b0, 1'b0, 1};
        vecs[6] = '{"gaps_nominal", 20, 19, 3, 1'b1, 1'b1, 0};
        vecs[7] = '{"random_full",  20, 19, 1, 1'b0, 1'b1, 0};

        #1;
        check_idle_outputs("reset");
        release_reset();

        for (int v = 0; v < 8; v++) begin
            int s0, e0, ms0, me0;
            s0 = start_cnt; e0 = err_cnt; ms0 = m_start; me0 = m_err;
            send_frame(vecs[v].n, vecs[v].last_at, vecs[v].gap_max, vecs[v].seq);
            chk({vecs[v].name, "_model_err"}, m_err - me0, vecs[v].exp_err);
            if (vecs[v].exp_start) begin
                start_and_handshake(vecs[v].name);
                chk({vecs[v].name, "_start_count"}, start_cnt - s0, m_start - ms0);
                check_arrays(vecs[v].name);
                if (vecs[v].seq) begin
                    chk("seq_a00", int'(input_data[0][0]), 1);
                    chk("seq_a01", int'(input_data[0][1]), 2);
                    chk("seq_a41", int'(input_data[4][1]), 10);
                    chk("seq_b00", int'(weights[0][0]), 11);
                    chk("seq_b14", int'(weights[1][4]), 20);
                end
            end else begin
                expect_error(vecs[v].name, s0, e0);
                chk({vecs[v].name, "_err_vs_model"}, err_cnt - e0, m_err - me0);
            end
        end

        for (int r = 0; r < 6; r++) begin
            int kind, n, last_at, s0, e0, ms0;
            kind = int'($urandom_range(2, 0));
            n = NF;
            last_at = NF - 1;
            if (kind == 1) begin
                n = int'($urandom_range(NF - 1, 1));
                last_at = n - 1;
            end else if (kind == 2) begin
                last_at = -1;
            end
            s0 = start_cnt; e0 = err_cnt; ms0 = m_start;
            send_frame(n, last_at, 2, 1'b0);
            if (m_start != ms0) begin
                start_and_handshake("rand");
                check_arrays("rand");
            end else begin
                expect_error("rand", s0, e0);
            end
        end

        // Asynchronous reset while loading B (after element 14).
        send_frame(14, -1, 0, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("rst_load_b");
        tick();
        release_reset();
        send_frame(NF, NF - 1, 1, 1'b1);
        start_and_handshake("after_rst_b");
        check_arrays("after_rst_b");

        // Asynchronous reset during WAIT_DONE.
        send_frame(NF, NF - 1, 0, 1'b0);
        sample();
        chk("pre_rst_start", int'(start_comp), 1);
        tick();
        tick();
        chk("pre_rst_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("rst_wait");
        tick();
        release_reset();
        send_frame(NF, NF - 1, 0, 1'b1);
        start_and_handshake("after_rst_w");
        check_arrays("after_rst_w");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/sys_array_matrix_loader.md
Name: sys_array_matrix_loader

Overview:
- Writer side of the matrix operand interface used by the systolic fetcher.
- Accepts a serial valid/ready element stream and fills the operand register arrays: A (input_data) first, then B (weights), both row-major.
- Once both arrays are complete, pulses start_comp, then holds the arrays stable until the fetcher reports completion.
- Sits between the host/test stream and sys_array_fetcher_split; one frame = A elements followed by B elements.

Parameters:
- DATA_WIDTH, 8, element width in bits (signed)
- ARRAY_A_W, 5, rows of matrix A
- ARRAY_A_L, 2, columns of matrix A
- ARRAY_W_W, 2, rows of matrix B (weights)
- ARRAY_W_L, 5, columns of matrix B (weights)

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  stream element valid
- in_data  input  DATA_WIDTH (signed)  stream element
- in_last  input  1  marks final element of a frame
- in_ready  output  1  loader accepts element this cycle
- comp_ready  input  1  fetcher ready output; level signal
- input_data  output  signed DATA_WIDTH array [0:ARRAY_A_W-1][0:ARRAY_A_L-1]  matrix A
- weights  output  signed DATA_WIDTH array [0:ARRAY_W_W-1][0:ARRAY_W_L-1]  matrix B
- start_comp  output  1  one-cycle start pulse to fetcher
- busy  output  1  high from start_comp until completion
- frame_err  output  1  one-cycle pulse on framing error
- done  output  1  one-cycle pulse when the fetcher completes

Behaviour:
- Reset (asynchronous, active low) values:
  - state LOAD_A; all counters 0; input_data and weights all 0.
  - in_ready, start_comp, busy, frame_err and done all 0.
  - in_ready rises the first cycle after reset deassertion.
- Transfer rule: an element is accepted on a clock edge where in_valid && in_ready. in_ready is registered state, not a combinational function of in_valid.
- State LOAD_A (in_ready=1):
  - On accept, write input_data[row][col]<=in_data.
  - col increments; at col==ARRAY_A_L-1, col wraps to 0 and row increments.
  - After element ARRAY_A_W*ARRAY_A_L-1: row and col go to 0, next state LOAD_B.
  - in_last on any accepted A element is a framing error.
- State LOAD_B (in_ready=1):
  - Same counting scheme, writing weights[row][col], with sizes ARRAY_W_W x ARRAY_W_L.
  - If the final B element is accepted with in_last=1, go to START.
  - If the final B element lacks in_last, or in_last arrives before the final B element, it is a framing error.
- Framing error:
  - frame_err pulses for 1 cycle; counters reset to 0; next state LOAD_A.
  - Array contents are left as partially written (not cleared); start_comp is not issued.
  - The offending element is consumed.
- State START:
  - in_ready=0; start_comp=1 for exactly this one cycle; busy<=1.
  - The comp_ready history register is loaded with the current comp_ready.
  - Next state WAIT_DONE.
- State WAIT_DONE:
  - in_ready=0; arrays frozen, because the fetcher re-reads them for every subtile.
  - Detect a comp_ready 0->1 transition using the registered previous value, so a comp_ready left high from an earlier run is ignored until it has dropped.
  - On the transition: done pulses 1 cycle, busy<=0, next state LOAD_A, and in_ready is 1 in the following cycle.
- Back-to-back frames: arrays are not cleared between frames; every element is overwritten by the next complete frame.
- Latency:
  - Last B accept edge -> start_comp high in the next cycle.
  - comp_ready rise -> done high 1 cycle later.
- Reset mid-operation, in any state: immediate return to reset values; any pending start or done is dropped.
- Counters are sized $clog2(max dimension)+1. No arithmetic is performed on data; in_data is stored verbatim.

Decomposition:
- Shared package: state enum {LOAD_A, LOAD_B, START, WAIT_DONE} as loader_state_t.
- One natural sub-module: matrix_row_col_counter, parameterised by ROWS and COLS.
  - Inputs: inc, clr. Outputs: row, col, wrap (asserted on the final element).
  - Instantiated twice, once for A and once for B.

Test Plan:
- Nominal frame, defaults:
  - Stimulus: 20 elements with values 1..20, in_last on the 20th.
  - Required: input_data[0][0]=1, [0][1]=2, [4][1]=10; weights[0][0]=11, [1][4]=20.
  - start_comp high exactly 1 cycle, the cycle after the 20th accept; busy=1.
- Completion handshake:
  - Stimulus: hold comp_ready=1 through START, drop it to 0 for 3 cycles, raise it to 1.
  - Required: done pulses only after the raise, not while comp_ready is initially high; in_ready=1 the next cycle.
- Early last:
  - Stimulus: in_last on element 7.
  - Required: frame_err 1-cycle pulse, no start_comp, and the next full 20-element frame loads correctly.
- Missing last:
  - Stimulus: 20 elements with in_last=0.
  - Required: frame_err on the 20th element, no start_comp.
- Backpressure and gaps:
  - Stimulus: random in_valid gaps during loading; in_valid held high during WAIT_DONE.
  - Required: identical array contents to the nominal frame; no element accepted while in_ready=0.
- Asynchronous reset:
  - Stimulus: reset_n low mid-LOAD_B (element 14) and, separately, during WAIT_DONE.
  - Required: all outputs 0 immediately, without waiting for a clock edge; a fresh frame afterwards loads and starts normally.
